// File: rtl/bank_fifo_ctrl.sv
// Circular-buffer FIFO controller that drives a 2048 x 8 banked RAM.
// Converts push/pop requests into RAM write/read strobes and returns popped bytes with a valid strobe.
module bank_fifo_ctrl #(
  parameter int DEPTH     = 2048,
  parameter int AW        = 11,
  parameter int DW        = 8,
  parameter int AF_MARGIN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_din,
  output logic          mem_ren,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_dout
);

  // Handshake: push/pop are requests with no ready signal; a push is taken only
  // when full is low and a pop only when empty is low. rd_valid is a one-cycle
  // strobe with no backpressure, arriving two cycles after an accepted pop.

  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_LVL_C = (AW+1)'(DEPTH - AF_MARGIN);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q, almost_full_q;
  logic          overflow_q, underflow_q;
  logic          rd_pending_q;
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;
  logic          push_ok, pop_ok;

  assign push_ok = push & ~full_q;
  assign pop_ok  = pop & ~empty_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + PTR_ONE;
    if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      rd_pending_q  <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      full_q        <= (count_d == DEPTH_C);
      empty_q       <= (count_d == '0);
      almost_full_q <= (count_d >= AF_LVL_C);
      overflow_q    <= push & full_q;
      underflow_q   <= pop & empty_q;
      // RAM output is valid the cycle after the read strobe; capture it then.
      rd_pending_q  <= pop_ok;
      rd_valid_q    <= rd_pending_q;
      if (rd_pending_q) rd_data_q <= mem_dout;
    end
  end

  assign mem_wen     = push_ok;
  assign mem_waddr   = wptr_q;
  assign mem_din     = din;
  assign mem_ren     = pop_ok;
  assign mem_raddr   = rptr_q;

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = almost_full_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_bank_fifo_ctrl.sv
// Directed and randomized bench for bank_fifo_ctrl with a RAM model and a queue-based FIFO reference.
module tb_bank_fifo_ctrl;
  localparam int DEPTH     = 2048;
  localparam int AW        = 11;
  localparam int DW        = 8;
  localparam int AF_MARGIN = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, overflow, underflow;
  logic [AW:0]   count;
  logic          mem_wen, mem_ren;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [DW-1:0] ram [0:DEPTH-1];

  bank_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .AF_MARGIN(AF_MARGIN)) dut (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_dout(mem_dout)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // Banked RAM: synchronous write, registered read
  always @(posedge clk) begin
    if (mem_wen) ram[mem_waddr] <= mem_din;
    if (mem_ren) mem_dout <= ram[mem_raddr];
  end

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  int            wr_idx, rd_idx;
  bit            p1_v, p2_v;
  logic [DW-1:0] p1_d, p2_d, last_data;
  bit            exp_ovf, exp_udf;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_regs();
    int n;
    n = exp_q.size();
    chk("count", 32'(count), n);
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= DEPTH - AF_MARGIN));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("underflow", 32'(underflow), 32'(exp_udf));
    chk("rd_valid", 32'(rd_valid), 32'(p2_v));
    chk("rd_data", 32'(rd_data), 32'(last_data));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; push = 1'b0; pop = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    wr_idx = 0; rd_idx = 0;
    p1_v = 0; p2_v = 0; p1_d = '0; p2_d = '0; last_data = '0;
    exp_ovf = 0; exp_udf = 0;
    check_regs();
  endtask

  // driver: one clock cycle of push/pop requests
  task automatic step(input bit p, input logic [DW-1:0] d, input bit q);
    bit            pok, qok;
    logic [DW-1:0] pd;
    @(negedge clk);
    rst = 1'b0; push = p; din = d; pop = q;
    #1;
    pok = p && (exp_q.size() < DEPTH);
    qok = q && (exp_q.size() > 0);
    chk("mem_wen", 32'(mem_wen), 32'(pok));
    chk("mem_ren", 32'(mem_ren), 32'(qok));
    chk("mem_waddr", 32'(mem_waddr), wr_idx);
    chk("mem_raddr", 32'(mem_raddr), rd_idx);
    if (pok) chk("mem_din", 32'(mem_din), 32'(d));
    exp_ovf = p && (exp_q.size() == DEPTH);
    exp_udf = q && (exp_q.size() == 0);
    pd = '0;
    if (qok) begin
      pd = exp_q.pop_front();
      rd_idx = (rd_idx + 1) % DEPTH;
    end
    if (pok) begin
      exp_q.push_back(d);
      wr_idx = (wr_idx + 1) % DEPTH;
    end
    @(posedge clk); #1;
    p2_v = p1_v; p2_d = p1_d;
    p1_v = qok;  p1_d = pd;
    if (p2_v) last_data = p2_d;
    check_regs();
  endtask

  initial begin
    do_reset();

    // three pushes then three pops, then drain the read pipeline
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0);

    // fill to full with addr[7:0], then one push too many
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 8'(i), 0);
    step(1, 8'hC3, 0);
    step(0, '0, 0);
    // full with simultaneous push+pop: only the pop goes through
    step(1, 8'hFF, 1);
    step(1, 8'hEE, 0);
    // drain everything, including the wrapped pointer region
    while (exp_q.size() > 0) step(0, '0, 1);
    step(0, '0, 0);
    step(0, '0, 0);

    // underflow, then push+pop on empty
    step(0, '0, 1);
    step(0, '0, 0);
    step(1, 8'hA5, 1);
    step(0, '0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0);

    // steady state at occupancy 5 with random data
    for (int i = 0; i < 5; i++) step(1, 8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 4000; i++) step(1, 8'($urandom_range(0, 255)), 1);
    for (int i = 0; i < 7; i++) step(0, '0, 1);

    // random mix of requests
    for (int i = 0; i < 600; i++)
      step(bit'($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)), bit'($urandom_range(0, 99) < 45));
    for (int i = 0; i < 40; i++) step(0, '0, 1);

    // reset right after an accepted pop with three entries stored
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 8'(8'h40 + i), 0);
    step(0, '0, 1);
    do_reset();
    step(1, 8'h5A, 0);
    step(0, '0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
